can_tx_bit_stuffer: RTL and testbench

//  Transmit-side counterpart of the receive path. It serialises a stream of frame bytes onto the CAN TX line.

---
 rtl/can_tx_bit_stuffer.sv | 242 ++++++++++++++++++++++++
 tb/tb_can_tx_bit_stuffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_bit_stuffer.sv
// ----------------------------------------------------------------------------
// can_tx_bit_stuffer
//   Serialises frame bytes onto the CAN TX line, MSB first, one bit per
//   i_tx_point strobe. It inserts a complement stuff bit after STUFF_LEN
//   identical bits when stuffing is enabled. A one-entry hold buffer
//   accepts the next byte while the current byte shifts out, so
//   back-to-back bytes leave no gap on the line.
//
// Ports
//   i_clk         system clock
//   i_rst         synchronous reset, active low
//   i_tx_point    one-clk strobe per bit time; o_tx changes only on it
//   i_start       begins a frame (ignored while busy)
//   i_stuff_en    stuffing enable, captured when start is accepted
//   i_abort       synchronous abort back to idle, no done/underrun pulse
//   i_data_in     byte to transmit
//   i_data_last   marks i_data_in as the final byte of the frame
//   i_data_valid  i_data_in / i_data_last are valid
//   o_data_ready  hold buffer empty while busy; transfer = valid && ready
//   o_tx          serial output, 1 = recessive
//   o_busy        frame in progress
//   o_done        one-clk pulse on normal frame completion
//   o_underrun    one-clk pulse when no byte is available at a byte boundary
// ----------------------------------------------------------------------------
module can_tx_bit_stuffer #(
    parameter int DATA_WIDTH = 8,   // must be >= 2
    parameter int STUFF_LEN  = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tx_point,
    input  logic                  i_start,
    input  logic                  i_stuff_en,
    input  logic                  i_abort,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_data_last,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_underrun
);

    localparam int RCW = $clog2(STUFF_LEN + 1);
    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [RCW-1:0] RUN_MAX  = RCW'(STUFF_LEN);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

    // S_BOUND: previous byte fully driven, waiting for the hold buffer.
    // S_END:   last byte (and any trailing stuff bit) driven, waiting for the
    //          strobe that returns the line to recessive.
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_SHIFT, S_STUFF, S_BOUND, S_END
    } state_t;

    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_sr;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_full;
    logic                  r_hold_last;
    logic                  r_cur_last;
    logic                  r_stuff_en;
    logic [RCW-1:0]        r_run_cnt;
    logic [BCW-1:0]        r_bit_cnt;
    logic                  r_prev;
    logic                  r_byte_end;   // stuff bit pending closes a byte
    logic                  r_tx;
    logic                  r_done;
    logic                  r_underrun;

    logic                  w_xfer;
    logic                  w_drive;      // a bit goes on the line this clk
    logic                  w_load_hold;  // hold buffer moves into sr this clk
    logic                  w_src_hold;   // the bit being driven comes from hold
    logic                  w_bit;
    logic [RCW-1:0]        w_run_nxt;
    logic                  w_byte_end;
    logic                  w_stuff_due;
    logic                  w_done;
    logic                  w_underrun;

    assign o_busy       = (r_state != S_IDLE);
    assign o_data_ready = o_busy && !r_hold_full;
    assign o_tx         = r_tx;
    assign o_done       = r_done;
    assign o_underrun   = r_underrun;

    assign w_xfer     = i_data_valid && o_data_ready;
    assign w_src_hold = (r_state == S_BOUND);

    // Bit to drive and the run bookkeeping it implies.
    always_comb begin
        w_bit      = r_sr[DATA_WIDTH-1];
        w_byte_end = (r_bit_cnt == BIT_LAST);
        if (r_state == S_STUFF) begin
            w_bit      = ~r_prev;
            w_byte_end = r_byte_end;
        end else if (w_src_hold) begin
            w_bit      = r_hold[DATA_WIDTH-1];
            w_byte_end = 1'b0;
        end

        if (r_state == S_STUFF)
            w_run_nxt = RCW'(1);
        else if (w_bit == r_prev)
            // saturate so the counter cannot wrap with stuffing disabled
            w_run_nxt = (r_run_cnt == RUN_MAX) ? r_run_cnt : r_run_cnt + RCW'(1);
        else
            w_run_nxt = RCW'(1);

        w_stuff_due = r_stuff_en && (r_state != S_STUFF) && (w_run_nxt == RUN_MAX);
    end

    // Next-state and event decode.
    always_comb begin
        w_next      = r_state;
        w_drive     = 1'b0;
        w_load_hold = 1'b0;
        w_done      = 1'b0;
        w_underrun  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start)
                    w_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_hold_full) begin
                    w_load_hold = 1'b1;
                    w_next      = S_SHIFT;
                end
            end
            S_SHIFT, S_STUFF: begin
                if (i_tx_point) begin
                    w_drive = 1'b1;
                    if (w_stuff_due)
                        w_next = S_STUFF;
                    else if (w_byte_end) begin
                        if (r_cur_last)
                            w_next = S_END;
                        else if (r_hold_full) begin
                            w_load_hold = 1'b1;
                            w_next      = S_SHIFT;
                        end else
                            w_next = S_BOUND;
                    end else
                        w_next = S_SHIFT;
                end
            end
            S_BOUND: begin
                if (r_hold_full) begin
                    // a late byte still makes it if it lands by this strobe
                    w_load_hold = 1'b1;
                    w_drive     = i_tx_point;
                    w_next      = (i_tx_point && w_stuff_due) ? S_STUFF : S_SHIFT;
                end else if (i_tx_point) begin
                    w_underrun = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            S_END: begin
                if (i_tx_point) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (i_abort)
            w_next = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst || i_abort) begin
            r_sr        <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_hold_last <= 1'b0;
            r_cur_last  <= 1'b0;
            r_stuff_en  <= 1'b0;
            r_run_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_prev      <= 1'b1;
            r_byte_end  <= 1'b0;
            r_tx        <= 1'b1;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_done     <= w_done;
            r_underrun <= w_underrun;

            if (r_state == S_IDLE && i_start) begin
                r_stuff_en <= i_stuff_en;
                r_run_cnt  <= '0;
                r_bit_cnt  <= '0;
                r_prev     <= 1'b1;
                r_byte_end <= 1'b0;
            end

            if (w_xfer) begin
                r_hold      <= i_data_in;
                r_hold_last <= i_data_last;
                r_hold_full <= 1'b1;
            end

            if (w_drive) begin
                r_tx       <= w_bit;
                r_prev     <= w_bit;
                r_run_cnt  <= w_run_nxt;
                r_byte_end <= w_byte_end && w_stuff_due;
            end

            if (w_load_hold) begin
                // when the first bit is driven straight from hold, sr gets the
                // remainder already shifted
                r_sr        <= (w_src_hold && w_drive) ? (r_hold << 1) : r_hold;
                r_bit_cnt   <= (w_src_hold && w_drive) ? BCW'(1) : '0;
                r_cur_last  <= r_hold_last;
                r_hold_full <= 1'b0;
            end else if (w_drive && r_state == S_SHIFT) begin
                r_sr      <= r_sr << 1;
                r_bit_cnt <= w_byte_end ? '0 : r_bit_cnt + BCW'(1);
            end

            if (w_done || w_underrun) begin
                r_tx        <= 1'b1;
                r_hold_full <= 1'b0;
                r_run_cnt   <= '0;
                r_bit_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_can_tx_bit_stuffer.sv
// ----------------------------------------------------------------------------
// tb_can_tx_bit_stuffer
//   Directed frames with hand-computed bit sequences. Expected line values
//   are queued per tx_point strobe; a monitor pops and compares on each
//   strobe. Frame-level results (done/underrun counts, idle state) are
//   checked after each frame.
// ----------------------------------------------------------------------------
module tb_can_tx_bit_stuffer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_point = 1'b0;
    logic       start = 1'b0;
    logic       stuff_en = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_last = 1'b0;
    logic       data_valid = 1'b0;
    logic       data_ready, tx, busy, done, underrun;

    can_tx_bit_stuffer #(.DATA_WIDTH(8), .STUFF_LEN(5)) dut (
        .i_clk(clk), .i_rst(rst), .i_tx_point(tx_point), .i_start(start),
        .i_stuff_en(stuff_en), .i_abort(abort), .i_data_in(data_in),
        .i_data_last(data_last), .i_data_valid(data_valid),
        .o_data_ready(data_ready), .o_tx(tx), .o_busy(busy), .o_done(done),
        .o_underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic tx;
        logic done;
        logic und;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   und_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one expected entry per strobe while a frame is expected.
    always begin : mon
        exp_t e;
        @(posedge clk);
        if (tx_point && exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            chk("tx_bit", tx, e.tx);
            chk("done_at_strobe", done, e.done);
            chk("underrun_at_strobe", underrun, e.und);
        end
    end

    always @(negedge clk) begin
        if (done)     done_cnt++;
        if (underrun) und_cnt++;
    end

    task automatic push_bits(input string s);
        exp_t e;
        for (int i = 0; i < s.len(); i++) begin
            e.tx   = (s.getc(i) == 8'h31);
            e.done = 1'b0;
            e.und  = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Called at a negedge; returns at a negedge with valid dropped.
    task automatic feed(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        data_in    = b;
        data_last  = last;
        data_valid = 1'b1;
        while (!data_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("data_ready_wait", data_ready, 1);
        @(negedge clk);
        data_valid = 1'b0;
        data_last  = 1'b0;
    endtask

    task automatic strobes(input int n);
        repeat (n) begin
            tx_point = 1'b1;
            @(negedge clk);
            tx_point = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input int nbytes,
                         input logic last, input logic se, input string bits,
                         input logic exp_done, input logic exp_und, input logic strobe_at_start);
        exp_t e;
        int   ns;
        done_cnt = 0;
        und_cnt  = 0;
        @(negedge clk);
        stuff_en = se;
        start    = 1'b1;
        tx_point = strobe_at_start;
        @(negedge clk);
        start    = 1'b0;
        tx_point = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("tx_recessive_after_start", tx, 1);
        push_bits(bits);
        e.tx   = 1'b1;
        e.done = exp_done;
        e.und  = exp_und;
        exp_q.push_back(e);
        ns = exp_q.size();
        fork
            begin
                feed(b0, (nbytes == 1) ? last : 1'b0);
                if (nbytes == 2) feed(b1, last);
            end
            begin
                repeat (8) @(negedge clk);
                strobes(ns);
            end
        join
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("busy_end", busy, 0);
        chk("tx_end", tx, 1);
        chk("ready_end", data_ready, 0);
        chk("done_count", done_cnt, exp_done);
        chk("underrun_count", und_cnt, exp_und);
    endtask

    task automatic abort_test(input logic use_rst);
        done_cnt = 0;
        und_cnt  = 0;
        @(negedge clk);
        stuff_en = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        push_bits("000");
        fork
            feed(8'h0F, 1'b1);
            begin
                repeat (8) @(negedge clk);
                strobes(3);
            end
        join
        chk("busy_before_abort", busy, 1);
        if (use_rst) rst = 1'b0;
        else         abort = 1'b1;
        @(negedge clk);
        rst   = 1'b1;
        abort = 1'b0;
        chk(use_rst ? "rst_tx" : "abort_tx", tx, 1);
        chk(use_rst ? "rst_busy" : "abort_busy", busy, 0);
        chk(use_rst ? "rst_ready" : "abort_ready", data_ready, 0);
        strobes(2);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_underrun", und_cnt, 0);
        chk("abort_tx_idle", tx, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_ready", data_ready, 0);
        chk("reset_done", done, 0);
        chk("reset_underrun", underrun, 0);
        rst = 1'b1;
        @(negedge clk);

        // 0xFF last, stuffed; start coincides with a strobe
        frame(8'hFF, 8'h00, 1, 1'b1, 1'b1, "111110111", 1'b1, 1'b0, 1'b1);
        // two zero bytes, stuffing runs across the byte boundary
        frame(8'h00, 8'h00, 2, 1'b1, 1'b1, "0000010000010000010", 1'b1, 1'b0, 1'b0);
        // stuff bit counts toward the following zero run
        frame(8'hF8, 8'h00, 1, 1'b1, 1'b1, "111110000", 1'b1, 1'b0, 1'b0);
        // stuffing disabled
        frame(8'hFF, 8'h00, 1, 1'b1, 1'b0, "11111111", 1'b1, 1'b0, 1'b0);
        // missing second byte -> underrun on 9th strobe
        frame(8'hA5, 8'h00, 1, 1'b0, 1'b1, "10100101", 1'b0, 1'b1, 1'b0);

        abort_test(1'b0);
        abort_test(1'b1);

        // recovery after abort/reset, no stuffing needed
        frame(8'h3C, 8'h00, 1, 1'b1, 1'b1, "00111100", 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
